// File: rtl/deadlock_detect_unit.sv
// Per-process deadlock detector: propagates the transitive blocked-on set,
// flags loop membership and forwards the report token around a detected loop.
module deadlock_detect_unit #(
  parameter int unsigned PROC_NUM = 2,
  parameter int unsigned PROC_ID  = 0
) (
  input  logic                         dl_clock,
  input  logic                         dl_reset,
  input  logic [PROC_NUM-1:0]          proc_dep_vld_vec,
  input  logic [PROC_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [PROC_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  output logic                         out_dep_vld,
  output logic [PROC_NUM-1:0]          out_dep_data,
  input  logic [PROC_NUM-1:0]          token_in_vec,
  output logic [PROC_NUM-1:0]          token_out_vec,
  input  logic                         dl_detect_in,
  input  logic                         origin,
  input  logic                         token_clear,
  output logic                         dl_detect_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    PASSED = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PROC_NUM-1:0] dep;
  logic [PROC_NUM-1:0] next_reach;
  logic [PROC_NUM-1:0] reach_q;
  logic                blocked;
  logic                in_loop_q;
  logic                is_origin_q, is_origin_d;
  logic                closed_q, closed_d;
  logic                close_pulse_q, close_pulse_d;
  logic [PROC_NUM-1:0] loop_sel, dep_sel;
  logic                found_loop, found_dep;
  logic [PROC_NUM-1:0] tok_out;

  // Self-dependence is meaningless, so the own bit is masked off.
  always_comb begin
    dep          = proc_dep_vld_vec;
    dep[PROC_ID] = 1'b0;
  end

  assign blocked = |dep;

  always_comb begin
    next_reach = dep;
    for (int unsigned j = 0; j < PROC_NUM; j++) begin
      if (dep[j] && in_chan_dep_vld_vec[j]) begin
        next_reach = next_reach | in_chan_dep_data_vec[j*PROC_NUM +: PROC_NUM];
      end
    end
  end

  always_ff @(posedge dl_clock) begin
    if (dl_reset) begin
      reach_q   <= '0;
      in_loop_q <= 1'b0;
    end else begin
      reach_q   <= blocked ? next_reach : '0;
      in_loop_q <= blocked & next_reach[PROC_ID];
    end
  end

  // Token target: prefer a neighbour whose set leads back here, else any dependence.
  always_comb begin
    loop_sel   = '0;
    dep_sel    = '0;
    found_loop = 1'b0;
    found_dep  = 1'b0;
    for (int unsigned j = 0; j < PROC_NUM; j++) begin
      if (!found_loop && dep[j] && in_chan_dep_data_vec[j*PROC_NUM + PROC_ID]) begin
        loop_sel[j] = 1'b1;
        found_loop  = 1'b1;
      end
      if (!found_dep && dep[j]) begin
        dep_sel[j] = 1'b1;
        found_dep  = 1'b1;
      end
    end
  end

  always_ff @(posedge dl_clock) begin
    if (dl_reset) begin
      state_q       <= IDLE;
      is_origin_q   <= 1'b0;
      closed_q      <= 1'b0;
      close_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_origin_q   <= is_origin_d;
      closed_q      <= closed_d;
      close_pulse_q <= close_pulse_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    is_origin_d   = is_origin_q;
    closed_d      = closed_q;
    close_pulse_d = 1'b0;
    tok_out       = '0;
    unique case (state_q)
      IDLE: begin
        is_origin_d = 1'b0;
        closed_d    = 1'b0;
        if (dl_detect_in && origin && in_loop_q) begin
          state_d     = HOLD;
          is_origin_d = 1'b1;
        end else if (dl_detect_in && (|token_in_vec) && blocked) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        tok_out = found_loop ? loop_sel : dep_sel;
        state_d = PASSED;
      end
      PASSED: begin
        // Only the origin reacts to a returning token, and only once per cycle trace.
        if (token_clear || !dl_detect_in) begin
          state_d = IDLE;
        end else if ((|token_in_vec) && is_origin_q && !closed_q) begin
          close_pulse_d = 1'b1;
          closed_d      = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign token_out_vec = tok_out;
  assign out_dep_data  = reach_q;
  assign out_dep_vld   = blocked & ~dl_reset;
  assign dl_detect_out = dl_detect_in
                         ? (((state_q == HOLD) && !is_origin_q) || close_pulse_q)
                         : in_loop_q;

endmodule

// File: tb/tb_deadlock_detect_unit.sv
// Scoreboard bench for deadlock_detect_unit: two instances (PROC_ID 0 and 1)
// driven independently; expectations are queued with stimulus and checked after each edge.
module tb_deadlock_detect_unit;

  logic       dl_clock = 1'b0;
  logic       dl_reset;

  logic [1:0] dep_a, vld_a, tin_a, tout_a, odata_a;
  logic [3:0] data_a;
  logic       ddin_a, org_a, clr_a, ddo_a, ovld_a;

  logic [1:0] dep_b, vld_b, tin_b, tout_b, odata_b;
  logic [3:0] data_b;
  logic       ddin_b, org_b, clr_b, ddo_b, ovld_b;

  always #5 dl_clock = ~dl_clock;

  deadlock_detect_unit #(.PROC_NUM(2), .PROC_ID(0)) u_a (
    .dl_clock             (dl_clock),
    .dl_reset             (dl_reset),
    .proc_dep_vld_vec     (dep_a),
    .in_chan_dep_vld_vec  (vld_a),
    .in_chan_dep_data_vec (data_a),
    .out_dep_vld          (ovld_a),
    .out_dep_data         (odata_a),
    .token_in_vec         (tin_a),
    .token_out_vec        (tout_a),
    .dl_detect_in         (ddin_a),
    .origin               (org_a),
    .token_clear          (clr_a),
    .dl_detect_out        (ddo_a)
  );

  deadlock_detect_unit #(.PROC_NUM(2), .PROC_ID(1)) u_b (
    .dl_clock             (dl_clock),
    .dl_reset             (dl_reset),
    .proc_dep_vld_vec     (dep_b),
    .in_chan_dep_vld_vec  (vld_b),
    .in_chan_dep_data_vec (data_b),
    .out_dep_vld          (ovld_b),
    .out_dep_data         (odata_b),
    .token_in_vec         (tin_b),
    .token_out_vec        (tout_b),
    .dl_detect_in         (ddin_b),
    .origin               (org_b),
    .token_clear          (clr_b),
    .dl_detect_out        (ddo_b)
  );

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [3:0]  exp;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // sel: unit*4 + {0:dl_detect_out, 1:token_out_vec, 2:out_dep_data, 3:out_dep_vld}
  function automatic logic [3:0] probe(input int unsigned sel);
    case (sel)
      0: return {3'b0, ddo_a};
      1: return {2'b0, tout_a};
      2: return {2'b0, odata_a};
      3: return {3'b0, ovld_a};
      4: return {3'b0, ddo_b};
      5: return {2'b0, tout_b};
      6: return {2'b0, odata_b};
      7: return {3'b0, ovld_b};
      default: return 4'hx;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int unsigned sel, input logic [3:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic expect_unit(input string tag, input int unsigned u, input logic d,
                             input logic [1:0] t, input logic [1:0] q, input logic v);
    expect_out({tag, "_ddo"},  u*4 + 0, {3'b0, d});
    expect_out({tag, "_tok"},  u*4 + 1, {2'b0, t});
    expect_out({tag, "_data"}, u*4 + 2, {2'b0, q});
    expect_out({tag, "_vld"},  u*4 + 3, {3'b0, v});
  endtask

  task automatic tick();
    exp_t e;
    @(posedge dl_clock);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check_val(e.tag, probe(e.sel), e.exp);
    end
  endtask

  task automatic clear_inputs();
    dep_a = '0; vld_a = '0; data_a = '0; tin_a = '0; ddin_a = 0; org_a = 0; clr_a = 0;
    dep_b = '0; vld_b = '0; data_b = '0; tin_b = '0; ddin_b = 0; org_b = 0; clr_b = 0;
  endtask

  initial begin
    clear_inputs();
    dl_reset = 1'b1;

    // Reset with random inputs
    repeat (3) begin
      dep_a = 2'($urandom); vld_a = 2'($urandom); data_a = 4'($urandom); tin_a = 2'($urandom);
      ddin_a = 1'($urandom); org_a = 1'($urandom); clr_a = 1'($urandom);
      dep_b = 2'($urandom); vld_b = 2'($urandom); data_b = 4'($urandom); tin_b = 2'($urandom);
      ddin_b = 1'($urandom); org_b = 1'($urandom); clr_b = 1'($urandom);
      expect_unit("rst_a", 0, 1'b0, 2'b00, 2'b00, 1'b0);
      expect_unit("rst_b", 1, 1'b0, 2'b00, 2'b00, 1'b0);
      tick();
    end
    clear_inputs();
    dl_reset = 1'b0;
    tick();

    // Two-process loop seen from process 0
    dep_a = 2'b10; vld_a = 2'b10; data_a = 4'b0100;
    expect_unit("loop", 0, 1'b1, 2'b00, 2'b11, 1'b1);
    tick();

    // Neighbour set without a path back: never flags
    data_a = 4'b1000;
    expect_out("noloop_data", 2, 4'h2);
    for (int i = 0; i < 1000; i++) begin
      expect_out("noloop_ddo", 0, 4'h0);
      tick();
    end

    // Origin report: origin and token together, origin wins
    data_a = 4'b0100;
    expect_out("reloop_ddo", 0, 4'h1);
    tick();
    ddin_a = 1; org_a = 1; tin_a = 2'b10;
    expect_unit("hold_org", 0, 1'b0, 2'b10, 2'b11, 1'b1);
    tick();
    org_a = 0; tin_a = 2'b00;
    expect_unit("passed_org", 0, 1'b0, 2'b00, 2'b11, 1'b1);
    tick();
    tin_a = 2'b10;
    expect_unit("close", 0, 1'b1, 2'b00, 2'b11, 1'b1);
    tick();
    tin_a = 2'b00;
    expect_unit("close_end", 0, 1'b0, 2'b00, 2'b11, 1'b1);
    tick();
    tin_a = 2'b10;
    expect_unit("close_again", 0, 1'b0, 2'b00, 2'b11, 1'b1);
    tick();
    tin_a = 2'b00; clr_a = 1;
    expect_out("clear_ddo", 0, 4'h0);
    tick();
    clr_a = 0; ddin_a = 0;
    expect_out("idle_loop_ddo", 0, 4'h1);
    tick();

    // Non-origin hop at process 1, then ring guard
    dep_b = 2'b01; ddin_b = 1; tin_b = 2'b01;
    expect_unit("hop", 1, 1'b1, 2'b01, 2'b01, 1'b1);
    tick();
    tin_b = 2'b00;
    expect_unit("hop_done", 1, 1'b0, 2'b00, 2'b01, 1'b1);
    tick();
    tin_b = 2'b01;
    expect_unit("ring_guard", 1, 1'b0, 2'b00, 2'b01, 1'b1);
    tick();
    tin_b = 2'b00;
    expect_unit("ring_quiet", 1, 1'b0, 2'b00, 2'b01, 1'b1);
    tick();
    ddin_b = 0;
    expect_unit("detect_drop", 1, 1'b0, 2'b00, 2'b01, 1'b1);
    tick();
    tin_b = 2'b01;
    expect_unit("tok_no_detect", 1, 1'b0, 2'b00, 2'b01, 1'b1);
    tick();
    tin_b = 2'b00; ddin_b = 1;
    expect_unit("still_idle", 1, 1'b0, 2'b00, 2'b01, 1'b1);
    tick();
    ddin_b = 0;

    // Blocking drops while reporting
    ddin_a = 1; org_a = 1;
    expect_unit("hold2", 0, 1'b0, 2'b10, 2'b11, 1'b1);
    tick();
    org_a = 0; dep_a = 2'b00;
    expect_unit("unblock", 0, 1'b0, 2'b00, 2'b00, 1'b0);
    tick();
    clr_a = 1;
    expect_unit("unblock_clr", 0, 1'b0, 2'b00, 2'b00, 1'b0);
    tick();
    clr_a = 0; ddin_a = 0;
    expect_out("unblock_idle", 0, 4'h0);
    tick();

    // Reset during a non-origin HOLD
    dep_a = 2'b10;
    expect_unit("reblock", 0, 1'b1, 2'b00, 2'b11, 1'b1);
    tick();
    ddin_a = 1; tin_a = 2'b10;
    expect_unit("hold_nonorg", 0, 1'b1, 2'b10, 2'b11, 1'b1);
    tick();
    tin_a = 2'b00; dl_reset = 1;
    expect_unit("rst_hold", 0, 1'b0, 2'b00, 2'b00, 1'b0);
    tick();
    dl_reset = 0; ddin_a = 0;
    expect_out("post_rst_tok", 1, 4'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
